cmp_flag_unit: RTL and testbench

Multi-cycle 32-bit magnitude comparator. It sits directly upstream of the 4-to-2 result selector in the 32-bit MIPS datapath. It compares operands A and B MSB-first in fixed-width chunks, with early termination, and produces one-hot lt/eq/gt flags plus a registered rtype qualifier. The selector consumes these to pick the writeback source. Operation uses a start/done handshake so the control FSM can stall while a comparison is in flight.

---
 rtl/cmp_flag_unit.sv | 120 ++++++++++++
 tb/tb_cmp_flag_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_flag_unit.sv
// Multi-cycle magnitude comparator: walks operands MSB-first one chunk per cycle,
// stops at the first differing chunk, and reports one-hot lt/eq/gt with a done pulse.
module cmp_flag_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             rtype_in,
    output logic             busy,
    output logic             done,
    output logic             rtype,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [IDXW-1:0]  idx, idx_nx;
    logic [WIDTH-1:0] a_q, a_nx;
    logic [WIDTH-1:0] b_q, b_nx;
    logic             rtype_nx, lt_nx, eq_nx, gt_nx;
    logic [WIDTH-1:0] sign_flip;
    logic [CHUNK-1:0] a_top, b_top;
    logic             accept;

    // Flipping the sign bit once at capture makes a signed compare an unsigned one,
    // so every chunk (including the top one) is compared the same way.
    assign sign_flip = {is_signed, {(WIDTH-1){1'b0}}};

    // Operands are shifted left after each equal chunk, so the chunk under test
    // always sits in the top CHUNK bits.
    assign a_top  = a_q[WIDTH-1 -: CHUNK];
    assign b_top  = b_q[WIDTH-1 -: CHUNK];
    assign accept = start && (state != S_COMPARE);

    assign busy = (state == S_COMPARE);
    assign done = (state == S_DONE);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nx = state;
        idx_nx   = idx;
        a_nx     = a_q;
        b_nx     = b_q;
        rtype_nx = rtype;
        lt_nx    = lt;
        eq_nx    = eq;
        gt_nx    = gt;

        case (state)
            S_IDLE: ;
            S_COMPARE: begin
                if (a_top != b_top) begin
                    gt_nx    = (a_top > b_top);
                    lt_nx    = (a_top < b_top);
                    state_nx = S_DONE;
                end else if (idx != '0) begin
                    idx_nx = idx - IDXW'(1);
                    a_nx   = a_q << CHUNK;
                    b_nx   = b_q << CHUNK;
                end else begin
                    eq_nx    = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Accept overrides the DONE->IDLE step, giving back-to-back operation.
        if (accept) begin
            a_nx     = a ^ sign_flip;
            b_nx     = b ^ sign_flip;
            rtype_nx = rtype_in;
            lt_nx    = 1'b0;
            eq_nx    = 1'b0;
            gt_nx    = 1'b0;
            idx_nx   = IDXW'(NCHUNK - 1);
            state_nx = S_COMPARE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            idx   <= IDXW'(NCHUNK - 1);
            a_q   <= '0;
            b_q   <= '0;
            rtype <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            a_q   <= a_nx;
            b_q   <= b_nx;
            rtype <= rtype_nx;
            lt    <= lt_nx;
            eq    <= eq_nx;
            gt    <= gt_nx;
        end
    end

endmodule

// File: tb/tb_cmp_flag_unit.sv
// Directed and randomized bench for cmp_flag_unit; expected flags and latency come
// from plain integer comparison and the position of the highest differing bit.
module tb_cmp_flag_unit;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             rtype_in;
    logic             busy, done, rtype, lt, eq, gt;

    int n_assert = 0;
    int n_fail   = 0;

    cmp_flag_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .rtype_in  (rtype_in),
        .busy      (busy),
        .done      (done),
        .rtype     (rtype),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: flags from integer compare; chunks examined from highest differing bit.
    task automatic model(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                         output logic [2:0] flags, output int k);
        logic [31:0] x;
        int          p;
        if (ts)
            flags = ($signed(ta) < $signed(tb)) ? 3'b100 :
                    ($signed(ta) > $signed(tb)) ? 3'b001 : 3'b010;
        else
            flags = (ta < tb) ? 3'b100 : (ta > tb) ? 3'b001 : 3'b010;
        x = ta ^ tb;
        p = -1;
        for (int i = 0; i < WIDTH; i++) if (x[i]) p = i;
        k = (p < 0) ? NCHUNK : NCHUNK - (p / CHUNK);
    endtask

    task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                         input logic tr, input logic st);
        a = ta; b = tb; is_signed = ts; rtype_in = tr; start = st;
    endtask

    // Entered at the negedge right after the accepting edge. Optionally holds start with
    // junk operands while busy, or chains a new request in the done cycle.
    task automatic finish_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                             input logic ts, input logic tr, input bit hold, input bit chain,
                             input logic [31:0] ca, input logic [31:0] cb,
                             input logic cs, input logic cr);
        logic [2:0] ef;
        int         k, n, busy_cycles, bad_flags, bad_rtype, both;
        bit         got;
        model(ta, tb, ts, ef, k);
        n = 0; got = 0; busy_cycles = 0; bad_flags = 0; bad_rtype = 0; both = 0;
        while (!got && n < 3 * NCHUNK) begin
            n++;
            if (busy && done) both++;
            if (done) begin
                got = 1;
                check({tag, " done_cycle"}, n, k + 1);
                check({tag, " flags"}, {lt, eq, gt}, ef);
                check({tag, " rtype"}, rtype, tr);
                if (chain) drive(ca, cb, cs, cr, 1'b1);
                else       start = 1'b0;
            end else begin
                if (busy) busy_cycles++;
                if ({lt, eq, gt} != 3'b000) bad_flags++;
                if (rtype !== tr) bad_rtype++;
                if (hold) drive($urandom, $urandom, $urandom_range(0, 1), ~tr, 1'b1);
                else      start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, " timeout"}, got, 1);
        check({tag, " busy_cycles"}, busy_cycles, k);
        check({tag, " flags_while_busy"}, bad_flags, 0);
        check({tag, " rtype_while_busy"}, bad_rtype, 0);
        check({tag, " busy_and_done"}, both, 0);
        if (chain) begin
            check({tag, " chain_accept"}, {busy, done, lt, eq, gt}, 5'b10000);
            check({tag, " chain_rtype"}, rtype, cr);
        end else begin
            check({tag, " idle_after"}, {busy, done}, 2'b00);
            check({tag, " flags_stable"}, {lt, eq, gt}, ef);
        end
    endtask

    initial begin : stim
        logic [31:0] ra, rb;
        logic        rs, rr;
        bit          rh;

        reset_n = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset held three cycles, released between edges.
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, rtype, lt, eq, gt}, 6'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, done, rtype, lt, eq, gt}, 6'b0);

        // Equal operands: worst-case latency.
        drive(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        finish_op("equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);

        // Top-chunk difference, unsigned then signed.
        drive(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        finish_op("early_unsigned", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        drive(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        finish_op("early_signed", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);

        // Low-chunk difference with start held during busy, then a chained signed op.
        drive(32'h0000_0005, 32'h0000_0009, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        finish_op("low_chunk_hold", 32'h0000_0005, 32'h0000_0009, 1'b0, 1'b1, 1, 1,
                  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        finish_op("back_to_back", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);

        // Abort during the second compare cycle.
        drive(32'd5, 32'd5, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check("abort_first_busy", busy, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {busy, done, rtype, lt, eq, gt}, 6'b0);
        @(negedge clk);
        check("abort_no_done", {busy, done, rtype, lt, eq, gt}, 6'b0);
        reset_n = 1'b1;
        @(negedge clk);
        drive(32'd5, 32'd5, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        finish_op("after_abort", 32'd5, 32'd5, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);

        // Randomized operations biased toward shared upper chunks.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = ra;
                2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = ra ^ ($urandom & 32'h0000_FFFF);
            endcase
            rs = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            rh = ($urandom_range(0, 3) == 0);
            drive(ra, rb, rs, rr, 1'b1);
            @(negedge clk);
            finish_op($sformatf("rand%0d", i), ra, rb, rs, rr, rh, 0, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
